// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared types and constants for the JTAG TAP controller.
//               - tap_state_t : 16 TAP states with the IEEE 1149.1 encodings
//               - OP_*        : fixed instruction opcodes
//               - tap_next()  : TMS-driven next-state function
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_EXIT2_DR   = 4'h0,
        ST_EXIT1_DR   = 4'h1,
        ST_SHIFT_DR   = 4'h2,
        ST_PAUSE_DR   = 4'h3,
        ST_SELECT_IR  = 4'h4,
        ST_UPDATE_DR  = 4'h5,
        ST_CAPTURE_DR = 4'h6,
        ST_SELECT_DR  = 4'h7,
        ST_EXIT2_IR   = 4'h8,
        ST_EXIT1_IR   = 4'h9,
        ST_SHIFT_IR   = 4'hA,
        ST_PAUSE_IR   = 4'hB,
        ST_RTI        = 4'hC,
        ST_UPDATE_IR  = 4'hD,
        ST_CAPTURE_IR = 4'hE,
        ST_TLR        = 4'hF
    } tap_state_t;

    localparam int OP_EXTEST = 0;
    localparam int OP_SAMPLE = 1;
    localparam int OP_IDCODE = 2;
    localparam int OP_USER0  = 3;
    localparam int IDCODE_W  = 32;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            ST_TLR:        n = tms ? ST_TLR       : ST_RTI;
            ST_RTI:        n = tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_DR:  n = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   n = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   n = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   n = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   n = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  n = tms ? ST_SELECT_DR : ST_RTI;
            ST_SELECT_IR:  n = tms ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   n = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   n = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   n = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   n = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  n = tms ? ST_SELECT_DR : ST_RTI;
            default:       n = ST_TLR;
        endcase
        return n;
    endfunction

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/jtag_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl_if
// Description : Pin and scan-chain bundle of the TAP controller.
//               slave  : seen by the TAP (pins/chain outs in, strobes out)
//               master : seen by the pin driver / scan fabric
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_tap_ctrl_if #(
    parameter int IR_W    = 4,
    parameter int N_CHAIN = 2
);
    logic                TMS;
    logic                TDI;
    logic                TDO;
    logic                tdo_en;
    logic                bsr_tdo;
    logic [N_CHAIN-1:0]  chain_tdo;
    logic [3:0]          tap_state;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic                bsr_sel;
    logic [N_CHAIN-1:0]  chain_sel;
    logic                extest_mode;
    logic [IR_W-1:0]     ir_q;

    modport slave (
        input  TMS, TDI, bsr_tdo, chain_tdo,
        output TDO, tdo_en, tap_state, capture_dr, shift_dr, update_dr,
               bsr_sel, chain_sel, extest_mode, ir_q
    );

    modport master (
        output TMS, TDI, bsr_tdo, chain_tdo,
        input  TDO, tdo_en, tap_state, capture_dr, shift_dr, update_dr,
               bsr_sel, chain_sel, extest_mode, ir_q
    );
endinterface : jtag_tap_ctrl_if
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : 16-state IEEE 1149.1 TAP state machine.
//   TCK     in  : clock, rising edge
//   TRST    in  : synchronous active-high reset -> Test-Logic-Reset
//   tms_i   in  : TAP mode select
//   state_o out : current TAP state
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  wire         TCK,
    input  wire         TRST,
    input  wire         tms_i,
    output tap_state_t  state_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        state_d = tap_next(state_q, tms_i);
    end

    assign state_o = state_q;

endmodule : jtag_tap_fsm
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : Parametrised JTAG TAP controller: IR, bypass and IDCODE
//               registers, instruction decode and TDO multiplexer.
//   TCK  in  : clock, rising edge
//   TRST in  : synchronous active-high reset
//   jtag     : pins, BSR/user-chain serial outs, DR strobes, selects, ir_q
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          N_CHAIN    = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
)(
    input  wire                TCK,
    input  wire                TRST,
    jtag_tap_ctrl_if.slave     jtag
);

    localparam logic [IR_W-1:0] IR_EXTEST = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(OP_IDCODE);

    tap_state_t            state;

    logic [IR_W-1:0]       ir_sr_q,  ir_sr_d;
    logic [IR_W-1:0]       ir_act_q, ir_act_d;
    logic                  bypass_q, bypass_d;
    logic [IDCODE_W-1:0]   idcode_q, idcode_d;

    logic                  sel_extest;
    logic                  sel_sample;
    logic                  sel_idcode;
    logic                  sel_bsr;
    logic [N_CHAIN-1:0]    sel_chain;
    logic                  sel_bypass;
    logic                  dr_tdo;

    jtag_tap_fsm u_fsm (
        .TCK     (TCK),
        .TRST    (TRST),
        .tms_i   (jtag.TMS),
        .state_o (state)
    );

    // ---------------- instruction decode ----------------
    assign sel_extest = (ir_act_q == IR_EXTEST);
    assign sel_sample = (ir_act_q == IR_SAMPLE);
    assign sel_idcode = (ir_act_q == IR_IDCODE);
    assign sel_bsr    = sel_extest | sel_sample;

    for (genvar k = 0; k < N_CHAIN; k++) begin : g_chain_sel
        assign sel_chain[k] = (ir_act_q == IR_W'(OP_USER0 + k));
    end

    // All-ones and every unused code fall through to BYPASS.
    assign sel_bypass = ~(sel_bsr | sel_idcode | (|sel_chain));

    // ---------------- register next state ----------------
    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_act_d = ir_act_q;
        bypass_d = bypass_q;
        idcode_d = idcode_q;
        case (state)
            ST_TLR:        ir_act_d = IR_IDCODE;
            ST_CAPTURE_IR: ir_sr_d  = IR_W'(1);
            ST_SHIFT_IR:   ir_sr_d  = {jtag.TDI, ir_sr_q[IR_W-1:1]};
            ST_UPDATE_IR:  ir_act_d = ir_sr_q;
            ST_CAPTURE_DR: begin
                bypass_d = 1'b0;
                if (sel_idcode) idcode_d = IDCODE_VAL;
            end
            ST_SHIFT_DR: begin
                bypass_d = jtag.TDI;
                if (sel_idcode) idcode_d = {jtag.TDI, idcode_q[IDCODE_W-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sr_q  <= '0;
            ir_act_q <= IR_IDCODE;
            bypass_q <= 1'b0;
            idcode_q <= '0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            ir_act_q <= ir_act_d;
            bypass_q <= bypass_d;
            idcode_q <= idcode_d;
        end
    end

    // ---------------- TDO multiplexer ----------------
    // At most one sel_chain bit is set, so the AND-OR picks that chain.
    always_comb begin
        dr_tdo = 1'b0;
        if (sel_bsr)         dr_tdo = jtag.bsr_tdo;
        else if (sel_idcode) dr_tdo = idcode_q[0];
        else if (sel_bypass) dr_tdo = bypass_q;
        else                 dr_tdo = |(sel_chain & jtag.chain_tdo);
    end

    always_comb begin
        jtag.TDO = 1'b0;
        if (state == ST_SHIFT_IR)      jtag.TDO = ir_sr_q[0];
        else if (state == ST_SHIFT_DR) jtag.TDO = dr_tdo;
    end

    // ---------------- outputs ----------------
    assign jtag.tdo_en      = (state == ST_SHIFT_IR) | (state == ST_SHIFT_DR);
    assign jtag.tap_state   = state;
    assign jtag.capture_dr  = (state == ST_CAPTURE_DR);
    assign jtag.shift_dr    = (state == ST_SHIFT_DR);
    assign jtag.update_dr   = (state == ST_UPDATE_DR);
    assign jtag.bsr_sel     = sel_bsr;
    assign jtag.chain_sel   = sel_chain;
    assign jtag.extest_mode = sel_extest;
    assign jtag.ir_q        = ir_act_q;

endmodule : jtag_tap_ctrl
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_ctrl
// Description : Directed self-checking bench for jtag_tap_ctrl
//               (IR_W=4, N_CHAIN=2, IDCODE 32'h1000_0001).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;

    localparam int IR_W    = 4;
    localparam int N_CHAIN = 2;

    logic tck;
    logic trst;
    int   n_checks;
    int   n_errors;

    logic [31:0] id_bits;
    logic [3:0]  ir_bits;
    logic [5:0]  byp_obs;
    logic [4:0]  byp_pat;

    jtag_tap_ctrl_if #(.IR_W(IR_W), .N_CHAIN(N_CHAIN)) bus ();

    jtag_tap_ctrl #(
        .IR_W       (IR_W),
        .N_CHAIN    (N_CHAIN),
        .IDCODE_VAL (32'h1000_0001)
    ) u_dut (
        .TCK  (tck),
        .TRST (trst),
        .jtag (bus.slave)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply TMS/TDI, take one rising edge, sample 1 time unit later.
    task automatic step(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    // From RTI: shift op into IR (LSB first), return TDO bits seen, end in RTI.
    task automatic load_ir(input logic [3:0] op, output logic [3:0] seen);
        step(1'b1, 1'b0);  // Select-DR
        step(1'b1, 1'b0);  // Select-IR
        step(1'b0, 1'b0);  // Capture-IR
        step(1'b0, 1'b0);  // Shift-IR
        for (int i = 0; i < 4; i++) begin
            seen[i] = bus.TDO;
            step((i == 3), op[i]);
        end
        step(1'b1, 1'b0);  // Update-IR
        step(1'b0, 1'b0);  // RTI
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        trst          = 1'b1;
        bus.TMS       = 1'b0;
        bus.TDI       = 1'b0;
        bus.bsr_tdo   = 1'b0;
        bus.chain_tdo = '0;

        // ---- reset ----
        @(posedge tck); #1;
        check("rst_state",  32'(bus.tap_state), 32'hF);
        check("rst_ir",     32'(bus.ir_q), 32'h2);
        check("rst_tdoen",  32'(bus.tdo_en), 32'h0);
        check("rst_tdo",    32'(bus.TDO), 32'h0);
        check("rst_strobe", 32'({bus.capture_dr, bus.shift_dr, bus.update_dr}), 32'h0);
        check("rst_sel",    32'({bus.bsr_sel, bus.chain_sel, bus.extest_mode}), 32'h0);
        @(posedge tck); #1;
        trst = 1'b0;
        step(1'b0, 1'b0);
        check("rti_state",  32'(bus.tap_state), 32'hC);
        check("rti_ir",     32'(bus.ir_q), 32'h2);
        check("rti_extest", 32'(bus.extest_mode), 32'h0);
        check("rti_tdo",    32'(bus.TDO), 32'h0);

        // ---- IDCODE scan ----
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("cap_dr", 32'(bus.capture_dr), 32'h1);
        step(1'b0, 1'b0);
        check("sdr_state", 32'(bus.tap_state), 32'h2);
        check("sdr_tdoen", 32'(bus.tdo_en), 32'h1);
        for (int i = 0; i < 32; i++) begin
            id_bits[i] = bus.TDO;
            step(1'b0, 1'b0);
        end
        check("idcode", id_bits, 32'h1000_0001);

        // ---- five TMS=1 from Shift-DR ----
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tms5_state", 32'(bus.tap_state), 32'hF);
        check("tms5_ir",    32'(bus.ir_q), 32'h2);
        step(1'b0, 1'b0);

        // ---- BYPASS via all-ones ----
        load_ir(4'hF, ir_bits);
        check("ir_capture", 32'(ir_bits), 32'h1);
        check("ir_bypass",  32'(bus.ir_q), 32'hF);
        check("byp_sel",    32'({bus.bsr_sel, bus.chain_sel}), 32'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        byp_pat = 5'b11001;  // bit0 applied first: 1,0,0,1,1
        byp_obs[0] = bus.TDO;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, byp_pat[i]);
            byp_obs[i+1] = bus.TDO;
        end
        check("bypass_stream", 32'(byp_obs), 32'h32);  // 0,1,0,0,1,1
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pause_state", 32'(bus.tap_state), 32'h3);
        check("pause_tdo",   32'({bus.tdo_en, bus.TDO}), 32'h0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("upd_dr", 32'(bus.update_dr), 32'h1);
        step(1'b0, 1'b0);

        // ---- USER1 chain ----
        load_ir(4'h4, ir_bits);
        check("user1_ir",  32'(bus.ir_q), 32'h4);
        check("user1_sel", 32'(bus.chain_sel), 32'h2);
        check("user1_bsr", 32'(bus.bsr_sel), 32'h0);
        step(1'b1, 1'b0);
        check("cap_pre",  32'(bus.capture_dr), 32'h0);
        step(1'b0, 1'b0);
        check("cap_on",   32'(bus.capture_dr), 32'h1);
        step(1'b0, 1'b0);
        check("cap_post", 32'({bus.capture_dr, bus.shift_dr}), 32'h1);
        for (int i = 0; i < 4; i++) begin
            bus.chain_tdo = {i[0], ~i[0]};
            #1;
            check("chain1_tdo", 32'(bus.TDO), 32'(i[0]));
            step(1'b0, 1'b0);
        end
        bus.chain_tdo = '0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // ---- EXTEST, BSR path, TRST mid IR shift ----
        load_ir(4'h0, ir_bits);
        check("extest_ir",   32'(bus.ir_q), 32'h0);
        check("extest_mode", 32'({bus.extest_mode, bus.bsr_sel}), 32'h3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        bus.bsr_tdo = 1'b1; #1;
        check("bsr_tdo_1", 32'(bus.TDO), 32'h1);
        bus.bsr_tdo = 1'b0; #1;
        check("bsr_tdo_0", 32'(bus.TDO), 32'h0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);  // Shift-IR
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        trst = 1'b1;
        step(1'b0, 1'b1);
        trst = 1'b0;
        check("abort_state",  32'(bus.tap_state), 32'hF);
        check("abort_ir",     32'(bus.ir_q), 32'h2);
        check("abort_extest", 32'({bus.extest_mode, bus.bsr_sel}), 32'h0);
        check("abort_tdo",    32'({bus.tdo_en, bus.TDO}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_jtag_tap_ctrl
`default_nettype wire
